// File: rtl/ps2_kbd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_kbd_rx
// Purpose  : PS/2 keyboard receiver. Synchronises and de-glitches the
//            keyboard lines, deframes 11-bit frames with odd-parity and
//            stop-bit checking, and queues scan codes in a show-ahead FIFO
//            that the bus reads as {ps2_ready, key}. A rising edge on
//            ps2_rd pops one entry.
// Options  : PS2_BREAK_FILTER_EN - when defined, a valid F0 break prefix and
//            the byte that follows it are swallowed instead of queued.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_kbd_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILT_LEN    = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ps2_rd,
    output logic [7:0] key,
    output logic       ps2_ready,
    output logic       overflow,
    output logic       parity_err
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int PW  = AW + 1;
    localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // ---------------- input conditioning ----------------
    logic           clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic           filt_q, fall_q;
    logic [FCW-1:0] filt_cnt_q;

    // Two-stage synchronisers for both asynchronous keyboard lines.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Glitch filter: the filtered clock flips only after FILT_LEN consecutive
    // differing samples; fall_q pulses for one cycle on a 1->0 flip.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (clk_s2_q == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FCW'(FILT_LEN - 1)) begin
                filt_q     <= clk_s2_q;
                filt_cnt_q <= '0;
                fall_q     <= filt_q;
            end else begin
                filt_cnt_q <= filt_cnt_q + FCW'(1);
            end
        end
    end

    // ---------------- frame FSM ----------------
    state_t         state_q, state_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           par_q, par_d;
    logic [TOW-1:0] to_cnt_q, to_cnt_d;
    logic           push_w, perr_set_w, perr_clr_w;
`ifdef PS2_BREAK_FILTER_EN
    logic           skip_q, skip_d;
`endif

    // Frame state and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
            par_q    <= 1'b0;
            to_cnt_q <= '0;
`ifdef PS2_BREAK_FILTER_EN
            skip_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            to_cnt_q <= to_cnt_d;
`ifdef PS2_BREAK_FILTER_EN
            skip_q   <= skip_d;
`endif
        end
    end

    // Next-state logic: advances only on a filtered falling edge; a stalled
    // frame is abandoned once the inter-edge counter expires.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        push_w     = 1'b0;
        perr_set_w = 1'b0;
        perr_clr_w = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        skip_d     = skip_q;
`endif
        to_cnt_d   = (state_q == ST_IDLE || fall_q) ? '0 : to_cnt_q + TOW'(1);

        if (fall_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d  = ST_DATA;
                        bitcnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_d  = {dat_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        perr_clr_w = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else if (shift_q == 8'hF0) begin
                            skip_d = 1'b1;
                        end else begin
                            push_w = 1'b1;
                        end
`else
                        push_w = 1'b1;
`endif
                    end else begin
                        perr_set_w = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && to_cnt_q == TOW'(TIMEOUT_CYC - 1)) begin
            state_d = ST_IDLE;
`ifdef PS2_BREAK_FILTER_EN
            skip_d  = 1'b0;
`endif
        end
    end

    // ---------------- scan-code FIFO ----------------
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        rd_prev_q;
    logic [7:0]  key_q, key_d, head_w;
    logic        ready_q, ready_d, ovf_q, ovf_d, perr_q, perr_d;
    logic        empty_w, full_w, pop_w, wr_en_w;

    // Pointer arithmetic and the registered show-ahead head value.
    always_comb begin
        empty_w  = (wr_ptr_q == rd_ptr_q);
        full_w   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop_w    = ps2_rd && !rd_prev_q && !empty_w;
        wr_en_w  = push_w && (!full_w || pop_w);
        wr_ptr_d = wr_ptr_q + PW'(wr_en_w);
        rd_ptr_d = rd_ptr_q + PW'(pop_w);
        // A byte written this cycle becomes the head only if nothing older remains.
        if (wr_en_w && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            head_w = shift_q;
        end else begin
            head_w = mem_q[rd_ptr_d[AW-1:0]];
        end
        ready_d  = (wr_ptr_d != rd_ptr_d);
        key_d    = ready_d ? head_w : 8'h00;
        ovf_d    = ovf_q;
        if (pop_w) begin
            ovf_d = 1'b0;
        end else if (push_w && full_w) begin
            ovf_d = 1'b1;
        end
        perr_d   = perr_q;
        if (perr_set_w) begin
            perr_d = 1'b1;
        end else if (perr_clr_w) begin
            perr_d = 1'b0;
        end
    end

    // FIFO storage (no reset needed: contents are only visible when valid).
    always_ff @(posedge clk) begin
        if (wr_en_w) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    // FIFO pointers, read-strobe edge history and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_prev_q <= 1'b0;
            key_q     <= 8'h00;
            ready_q   <= 1'b0;
            ovf_q     <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_prev_q <= ps2_rd;
            key_q     <= key_d;
            ready_q   <= ready_d;
            ovf_q     <= ovf_d;
            perr_q    <= perr_d;
        end
    end

    assign key        = key_q;
    assign ps2_ready  = ready_q;
    assign overflow   = ovf_q;
    assign parity_err = perr_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_kbd_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_kbd_rx
// Purpose  : Scoreboard bench for ps2_kbd_rx. Frames are driven bit-by-bit on
//            the raw keyboard lines; a queue-based model of the FIFO holds
//            the expected scan codes and a monitor compares on every read.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_kbd_rx;

    localparam int DEPTH = 8;
    localparam int FL    = 8;
    localparam int TO    = 3000;
    localparam int HALF  = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ps2_rd = 1'b0;
    logic [7:0] key;
    logic       ps2_ready, overflow, parity_err;

    ps2_kbd_rx #(
        .FIFO_DEPTH  (DEPTH),
        .FILT_LEN    (FL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_rd     (ps2_rd),
        .key        (key),
        .ps2_ready  (ps2_ready),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: expected FIFO contents and sticky flags.
    byte unsigned exp_q[$];
    bit  exp_ovf  = 1'b0;
    bit  exp_perr = 1'b0;
    bit  m_skip   = 1'b0;

    int  last_fall_cyc  = 0;
    int  ready_rise_cyc = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b, input bit bad);
        logic p;
        p = ~(^b) ^ bad;
        return {1'b1, p, b, 1'b0};
    endfunction

    // Model: a frame is accepted when its parity and stop bit are good.
    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            exp_perr = 1'b1;
            return;
        end
        exp_perr = 1'b0;
`ifdef PS2_BREAK_FILTER_EN
        if (m_skip) begin
            m_skip = 1'b0;
            return;
        end
        if (b == 8'hF0) begin
            m_skip = 1'b1;
            return;
        end
`endif
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovf = 1'b1;
    endtask

    task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data = f[i];
            if (glitch) begin
                wait_cyc(8);
                ps2_clk = 1'b0;
                wait_cyc(3);
                ps2_clk = 1'b1;
                wait_cyc(HALF / 2 - 11);
            end else begin
                wait_cyc(HALF / 2);
            end
            ps2_clk       = 1'b0;
            last_fall_cyc = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
            wait_cyc(HALF / 2);
        end
        ps2_data = 1'b1;
    endtask

    task automatic check_state(input string tag);
        @(negedge clk);
        check({tag, ".ready"}, ps2_ready, exp_q.size() > 0);
        check({tag, ".key"}, key, (exp_q.size() > 0) ? exp_q[0] : 8'h00);
        check({tag, ".overflow"}, overflow, exp_ovf);
        check({tag, ".parity_err"}, parity_err, exp_perr);
        wait_cyc(1);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad, input bit glitch);
        send_bits(mkframe(b, bad), 11, glitch);
        model_frame(b, !bad);
        wait_cyc(5);
        check_state($sformatf("frame_%02h", b));
    endtask

    task automatic do_read(input int len);
        ps2_rd = 1'b1;
        wait_cyc(len);
        ps2_rd = 1'b0;
        wait_cyc(3);
    endtask

    // Monitor: on every read-strobe rising edge, compare the presented head
    // with the scoreboard and retire it.
    logic rd_prev_m = 1'b0;
    logic ready_prev_m = 1'b0;
    always @(negedge clk) begin
        if (rst && ps2_rd && !rd_prev_m) begin
            if (exp_q.size() > 0) begin
                byte unsigned e;
                e = exp_q.pop_front();
                check("pop.key", key, e);
                check("pop.ready", ps2_ready, 1'b1);
                exp_ovf = 1'b0;
            end else begin
                check("pop_empty.key", key, 8'h00);
                check("pop_empty.ready", ps2_ready, 1'b0);
            end
        end
        if (ps2_ready && !ready_prev_m) ready_rise_cyc = cyc;
        rd_prev_m    = ps2_rd;
        ready_prev_m = ps2_ready;
    end

    initial begin
        // Reset state
        wait_cyc(3);
        check_state("reset");
        rst = 1'b1;
        wait_cyc(5);

        // Basic frame, latency from the raw stop-bit fall, single 5-cycle read
        ready_rise_cyc = -1;
        send_frame(8'h1C, 1'b0, 1'b0);
        check("ready_latency",
              (ready_rise_cyc > last_fall_cyc) && (ready_rise_cyc - last_fall_cyc <= FL + 5), 1);
        do_read(5);
        wait_cyc(10);
        check_state("after_long_read");

        // Parity failure then recovery
        send_frame(8'h1C, 1'b1, 1'b0);
        send_frame(8'h32, 1'b0, 1'b0);
        do_read(1);

        // Overflow: nine frames into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            do_read(2);
            check_state("drain");
        end
        do_read(1);

        // Stalled frame must time out and not corrupt the next frame
        send_bits(mkframe(8'h77, 1'b0), 4, 1'b0);
        wait_cyc(TO + 10);
        m_skip = 1'b0;
        check_state("timeout");
        send_frame(8'h5A, 1'b0, 1'b0);
        do_read(1);

        // Short low glitches on the keyboard clock are ignored
        send_frame(8'hA5, 1'b0, 1'b1);
        do_read(1);

        // Reset in the middle of a frame with a byte queued
        send_frame(8'h1C, 1'b0, 1'b0);
        send_bits(mkframe(8'h3C, 1'b0), 5, 1'b0);
        rst = 1'b0;
        wait_cyc(2);
        exp_q.delete();
        exp_ovf  = 1'b0;
        exp_perr = 1'b0;
        m_skip   = 1'b0;
        check_state("mid_reset");
        rst = 1'b1;
        wait_cyc(5);

        // Break-prefix sequence
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) do_read(1);

        // Randomised mix of frames (some corrupted, some glitched) and reads
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do_read($urandom_range(1, 4));
                check_state("rand_read");
            end else begin
                send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 4) == 0,
                           1'($urandom_range(0, 1)));
            end
        end
        for (int i = 0; i < DEPTH + 1; i++) do_read(1);
        check_state("final");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
